// File: rtl/dp_arbiter_pkg.sv
// Shared types for the data-pointer port arbiter: segment select encoding,
// FSM states and the latched access payload.
package dp_arbiter_pkg;

  typedef enum logic [1:0] {
    SREG_ES = 2'd0,
    SREG_CS = 2'd1,
    SREG_SS = 2'd2,
    SREG_DS = 2'd3
  } sreg_index_e;

  typedef enum logic [1:0] {
    DPA_IDLE,
    DPA_ISSUE,
    DPA_GAP
  } dp_arb_state_e;

  // Everything the bus control unit needs to run one access.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] dout;
    sreg_index_e sreg;
    logic        write;
    logic        wide;
    logic        io;
  } dp_payload_t;

endpackage

// File: rtl/dp_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr,
// wrapping modulo NREQ. Indices >= NREQ are never produced.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int          cand;
    logic [IW-1:0] cidx;
    // NOTE: every output and temporary gets a default before any branch so no
    // path leaves a value unassigned; that is what keeps this free of latches.
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    cidx  = '0;
    // Scan from the far end down so the lowest rotation distance is written last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = cand[IW-1:0];
      if (req[cidx]) begin
        valid = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/dp_arbiter.sv
// Round-robin arbiter with grant lock sharing the bus control unit's single
// dp_* port between NREQ requesters; all outputs come straight from flops.
module dp_arbiter
  import dp_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               ce_1,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*16-1:0] req_addr,
  input  logic [NREQ*16-1:0] req_dout,
  input  logic [NREQ*2-1:0]  req_sreg,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ-1:0]    req_wide,
  input  logic [NREQ-1:0]    req_io,
  output logic [NREQ-1:0]    req_done,
  output logic [15:0]        req_din,
  output logic [IW-1:0]      grant_idx,
  output logic               busy,
  output logic [15:0]        dp_addr,
  output logic [15:0]        dp_dout,
  output logic [1:0]         dp_sreg,
  output logic               dp_write,
  output logic               dp_wide,
  output logic               dp_io,
  output logic               dp_req,
  input  logic [15:0]        dp_din,
  input  logic               dp_ready
);

  dp_arb_state_e   state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic            locked_q, locked_d;
  dp_payload_t     pay_q, pay_d;
  logic            dp_req_q, dp_req_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [15:0]     din_q, din_d;

  logic [NREQ-1:0] owner_mask;
  logic            owner_valid;
  logic            owner_lock;
  logic            lock_eff;
  logic [NREQ-1:0] cand_req;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   grant_next;
  dp_payload_t     win_pay;

  assign owner_mask  = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
  assign owner_valid = |(req_valid & owner_mask);
  assign owner_lock  = |(req_lock & owner_mask);

  // An owner that has neither a request nor a lock asserted gives the lock up
  // right here in IDLE, so an abandoned lock cannot starve everyone forever.
  assign lock_eff = locked_q & (owner_valid | owner_lock);
  assign cand_req = lock_eff ? (req_valid & owner_mask) : req_valid;

  assign grant_next = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (cand_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    win_pay       = '0;
    win_pay.addr  = req_addr[{pick_idx, 4'b0000} +: 16];
    win_pay.dout  = req_dout[{pick_idx, 4'b0000} +: 16];
    win_pay.sreg  = sreg_index_e'(req_sreg[{pick_idx, 1'b0} +: 2]);
    win_pay.write = req_write[pick_idx];
    win_pay.wide  = req_wide[pick_idx];
    win_pay.io    = req_io[pick_idx];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    pay_d    = pay_q;
    dp_req_d = dp_req_q;
    busy_d   = busy_q;
    done_d   = '0;
    din_d    = din_q;

    unique case (state_q)
      DPA_IDLE: begin
        locked_d = lock_eff;
        if (pick_valid) begin
          grant_d  = pick_idx;
          pay_d    = win_pay;
          dp_req_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = DPA_ISSUE;
        end
      end

      DPA_ISSUE: begin
        if (dp_ready) begin
          dp_req_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = owner_mask;
          if (!pay_q.write) din_d = dp_din;
          locked_d = owner_lock;
          // A kept lock leaves the pointer alone so fairness resumes where it stopped.
          if (!owner_lock) rr_ptr_d = grant_next;
          state_d  = DPA_GAP;
        end
      end

      DPA_GAP: begin
        state_d = DPA_IDLE;
      end

      default: begin
        dp_req_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = DPA_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the simulator runs blocks.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= DPA_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      locked_q <= 1'b0;
      pay_q    <= '0;
      dp_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      din_q    <= '0;
    end else if (ce_1) begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      pay_q    <= pay_d;
      dp_req_q <= dp_req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      din_q    <= din_d;
    end
  end

  assign req_done  = done_q;
  assign req_din   = din_q;
  assign grant_idx = grant_q;
  assign busy      = busy_q;
  assign dp_req    = dp_req_q;
  assign dp_addr   = pay_q.addr;
  assign dp_dout   = pay_q.dout;
  assign dp_sreg   = pay_q.sreg;
  assign dp_write  = pay_q.write;
  assign dp_wide   = pay_q.wide;
  assign dp_io     = pay_q.io;

endmodule

// File: tb/tb_dp_arbiter.sv
// Self-checking bench for dp_arbiter: directed corner sequences, a vector
// table of arbitration outcomes, and randomized traffic against a rule model.
module tb_dp_arbiter;
  import dp_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int IW   = $clog2(NREQ);

  logic               clk = 1'b0;
  logic               n_reset;
  logic               ce_1;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*16-1:0] req_addr;
  logic [NREQ*16-1:0] req_dout;
  logic [NREQ*2-1:0]  req_sreg;
  logic [NREQ-1:0]    req_write;
  logic [NREQ-1:0]    req_wide;
  logic [NREQ-1:0]    req_io;
  logic [NREQ-1:0]    req_done;
  logic [15:0]        req_din;
  logic [IW-1:0]      grant_idx;
  logic               busy;
  logic [15:0]        dp_addr;
  logic [15:0]        dp_dout;
  logic [1:0]         dp_sreg;
  logic               dp_write;
  logic               dp_wide;
  logic               dp_io;
  logic               dp_req;
  logic [15:0]        dp_din;
  logic               dp_ready;

  dp_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .ce_1      (ce_1),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_dout  (req_dout),
    .req_sreg  (req_sreg),
    .req_write (req_write),
    .req_wide  (req_wide),
    .req_io    (req_io),
    .req_done  (req_done),
    .req_din   (req_din),
    .grant_idx (grant_idx),
    .busy      (busy),
    .dp_addr   (dp_addr),
    .dp_dout   (dp_dout),
    .dp_sreg   (dp_sreg),
    .dp_write  (dp_write),
    .dp_wide   (dp_wide),
    .dp_io     (dp_io),
    .dp_req    (dp_req),
    .dp_din    (dp_din),
    .dp_ready  (dp_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester-side view of each pending access.
  logic        act    [NREQ];
  logic        lk     [NREQ];
  logic [15:0] a_addr [NREQ];
  logic [15:0] a_dout [NREQ];
  logic [1:0]  a_sreg [NREQ];
  logic        a_wr   [NREQ];
  logic        a_wd   [NREQ];
  logic        a_io   [NREQ];

  // Arbitration rule model.
  int          m_rr;
  int          m_owner;
  bit          m_locked;
  logic [15:0] exp_din;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  lock;
    logic        wr;
    int          exp_grant;
    logic [15:0] exp_din;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = act[i];
      req_lock[i]            = lk[i];
      req_addr[16*i +: 16]   = a_addr[i];
      req_dout[16*i +: 16]   = a_dout[i];
      req_sreg[2*i +: 2]     = a_sreg[i];
      req_write[i]           = a_wr[i];
      req_wide[i]            = a_wd[i];
      req_io[i]              = a_io[i];
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      act[i] = 1'b0;
      lk[i]  = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] addr, input logic [15:0] dout,
                         input logic [1:0] sreg, input logic wr, input logic wd,
                         input logic io, input logic lock);
    act[i]    = 1'b1;
    lk[i]     = lock;
    a_addr[i] = addr;
    a_dout[i] = dout;
    a_sreg[i] = sreg;
    a_wr[i]   = wr;
    a_wd[i]   = wd;
    a_io[i]   = io;
  endtask

  task automatic raise(input int i);
    set_req(i, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0));
  endtask

  function automatic logic [63:0] dut_payload();
    return 64'({dp_addr, dp_dout, dp_sreg, dp_write, dp_wide, dp_io});
  endfunction

  function automatic logic [63:0] req_payload(input int i);
    return 64'({a_addr[i], a_dout[i], a_sreg[i], a_wr[i], a_wd[i], a_io[i]});
  endfunction

  // Who wins when the arbiter is free, from the stated rules: a held lock
  // restricts the choice to its owner unless the owner has let go of both
  // request and lock; otherwise scan upward from the pointer with wrap.
  function automatic int model_pick();
    if (m_locked) begin
      if (act[m_owner] || lk[m_owner]) return act[m_owner] ? m_owner : -1;
      m_locked = 1'b0;
    end
    for (int k = 0; k < NREQ; k++)
      if (act[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  task automatic wait_grant(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (dp_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset  = 1'b0;
    dp_ready = 1'b0;
    clear_all();
    drive_reqs();
    @(negedge clk);
    n_reset  = 1'b1;
    m_rr     = 0;
    m_owner  = 0;
    m_locked = 1'b0;
    exp_din  = '0;
  endtask

  task automatic run_random(input int ncyc);
    int exp_win;
    int bus_cnt;
    int o;
    bit in_flight;
    bit exp_done;
    bit gap;
    exp_win   = -1;
    bus_cnt   = 0;
    o         = 0;
    in_flight = 1'b0;
    exp_done  = 1'b0;
    gap       = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (exp_win >= 0) begin
        check("rnd_grant_req", 64'(dp_req), 64'd1);
        check("rnd_grant_idx", 64'(grant_idx), 64'(exp_win));
        check("rnd_grant_payload", dut_payload(), req_payload(exp_win));
        check("rnd_grant_nodone", 64'(req_done), 64'd0);
        in_flight = 1'b1;
        o         = exp_win;
        m_owner   = exp_win;
        bus_cnt   = $urandom_range(0, 3);
      end else if (exp_done) begin
        check("rnd_done", 64'(req_done), 64'(3'b001 << o));
        check("rnd_din", 64'(req_din), 64'(exp_din));
        check("rnd_done_req_low", 64'(dp_req), 64'd0);
        check("rnd_done_busy_low", 64'(busy), 64'd0);
        m_locked  = lk[o];
        if (!lk[o]) m_rr = (o + 1) % NREQ;
        in_flight = 1'b0;
        gap       = 1'b1;
        if (lk[o] && $urandom_range(0, 1) == 1) raise(o);
        else begin
          act[o] = 1'b0;
          lk[o]  = 1'b0;
        end
      end else begin
        check("rnd_nodone", 64'(req_done), 64'd0);
        check("rnd_req_level", 64'(dp_req), 64'(in_flight));
        check("rnd_busy_level", 64'(busy), 64'(in_flight));
        if (in_flight) check("rnd_hold_payload", dut_payload(), req_payload(o));
      end

      for (int i = 0; i < NREQ; i++)
        if (!act[i] && $urandom_range(0, 2) == 0) raise(i);
      drive_reqs();
      exp_win  = -1;
      exp_done = 1'b0;
      if (in_flight) begin
        dp_din = 16'($urandom);
        if (bus_cnt == 0) begin
          dp_ready = 1'b1;
          if (!a_wr[o]) exp_din = dp_din;
          exp_done = 1'b1;
        end else begin
          dp_ready = 1'b0;
          bus_cnt--;
        end
      end else begin
        // Stray dp_ready outside an access must be ignored.
        dp_ready = 1'($urandom_range(0, 1));
        dp_din   = 16'($urandom);
        if (gap) gap = 1'b0;
        else exp_win = model_pick();
      end
    end
    dp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit         ok;
    logic [2:0] e_done;

    tbl[0]  = '{3'b111, 3'b000, 1'b0, 0, 16'hD000};
    tbl[1]  = '{3'b111, 3'b000, 1'b0, 1, 16'hD001};
    tbl[2]  = '{3'b111, 3'b000, 1'b0, 2, 16'hD002};
    tbl[3]  = '{3'b111, 3'b000, 1'b0, 0, 16'hD003};
    tbl[4]  = '{3'b111, 3'b000, 1'b0, 1, 16'hD004};
    tbl[5]  = '{3'b111, 3'b000, 1'b0, 2, 16'hD005};
    tbl[6]  = '{3'b010, 3'b010, 1'b0, 1, 16'hD006};
    tbl[7]  = '{3'b011, 3'b010, 1'b1, 1, 16'hD006};
    tbl[8]  = '{3'b011, 3'b000, 1'b0, 1, 16'hD008};
    tbl[9]  = '{3'b011, 3'b000, 1'b0, 0, 16'hD009};
    tbl[10] = '{3'b110, 3'b000, 1'b0, 1, 16'hD00A};
    tbl[11] = '{3'b101, 3'b000, 1'b0, 2, 16'hD00B};
    tbl[12] = '{3'b001, 3'b000, 1'b0, 0, 16'hD00C};
    tbl[13] = '{3'b100, 3'b100, 1'b1, 2, 16'hD00C};
    tbl[14] = '{3'b001, 3'b000, 1'b0, 0, 16'hD00E};

    n_reset  = 1'b0;
    ce_1     = 1'b1;
    dp_ready = 1'b0;
    dp_din   = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_all();
    drive_reqs();
    #1;
    check("rst_dp_addr",   64'(dp_addr),   64'd0);
    check("rst_dp_dout",   64'(dp_dout),   64'd0);
    check("rst_dp_sreg",   64'(dp_sreg),   64'd0);
    check("rst_dp_attr",   64'({dp_write, dp_wide, dp_io}), 64'd0);
    check("rst_dp_req",    64'(dp_req),    64'd0);
    check("rst_req_done",  64'(req_done),  64'd0);
    check("rst_req_din",   64'(req_din),   64'd0);
    check("rst_grant_idx", 64'(grant_idx), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;

    // Single read from requester 1, bus answers on the third ISSUE cycle.
    set_req(1, 16'h1234, 16'h0000, SREG_DS, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_reqs();
    @(negedge clk);
    check("a_latency_dp_req", 64'(dp_req), 64'd1);
    check("a_grant", 64'(grant_idx), 64'd1);
    check("a_addr", 64'(dp_addr), 64'h1234);
    check("a_wide_read", 64'({dp_wide, dp_write}), 64'b10);
    check("a_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("a_hold1", 64'(dp_req), 64'd1);
    @(negedge clk);
    check("a_hold2", 64'(dp_req), 64'd1);
    dp_ready = 1'b1;
    dp_din   = 16'hBEEF;
    @(negedge clk);
    check("a_done", 64'(req_done), 64'b010);
    check("a_din", 64'(req_din), 64'hBEEF);
    check("a_req_low", 64'(dp_req), 64'd0);
    act[1] = 1'b0;
    drive_reqs();
    dp_ready = 1'b0;
    dp_din   = '0;
    @(negedge clk);
    check("a_done_once", 64'(req_done), 64'd0);
    check("a_gap_req_low", 64'(dp_req), 64'd0);
    check("a_gap_busy_low", 64'(busy), 64'd0);

    // IO write from requester 2: payload held through ISSUE, read data untouched.
    set_req(2, 16'h5678, 16'h00A5, SREG_SS, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_reqs();
    @(negedge clk);
    check("b_grant", 64'(grant_idx), 64'd2);
    for (int n = 0; n < 3; n++) begin
      check("b_payload", dut_payload(), req_payload(2));
      check("b_dp_req", 64'(dp_req), 64'd1);
      if (n < 2) @(negedge clk);
    end
    dp_ready = 1'b1;
    dp_din   = 16'h1111;
    @(negedge clk);
    check("b_done", 64'(req_done), 64'b100);
    check("b_din_kept", 64'(req_din), 64'hBEEF);

    // Requester 0 arrives during GAP with dp_ready already high: ignored until ISSUE.
    act[2] = 1'b0;
    set_req(0, 16'h0042, 16'h0000, SREG_CS, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_reqs();
    dp_din = 16'h2222;
    @(negedge clk);
    check("x_gap_req_low", 64'(dp_req), 64'd0);
    check("x_gap_nodone", 64'(req_done), 64'd0);
    @(negedge clk);
    check("x_entry_req", 64'(dp_req), 64'd1);
    check("x_entry_grant", 64'(grant_idx), 64'd0);
    check("x_entry_nodone", 64'(req_done), 64'd0);
    @(negedge clk);
    check("x_done", 64'(req_done), 64'b001);
    check("x_din", 64'(req_din), 64'h2222);
    act[0]   = 1'b0;
    dp_ready = 1'b0;

    // Async reset while an access is in flight.
    set_req(2, 16'h0777, 16'h0000, SREG_ES, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_reqs();
    @(negedge clk);
    check("c_gap_req_low", 64'(dp_req), 64'd0);
    @(negedge clk);
    check("c_grant", 64'(grant_idx), 64'd2);
    check("c_req", 64'(dp_req), 64'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check("c_rst_req", 64'(dp_req), 64'd0);
    check("c_rst_busy", 64'(busy), 64'd0);
    check("c_rst_done", 64'(req_done), 64'd0);
    check("c_rst_grant", 64'(grant_idx), 64'd0);
    dp_ready = 1'b1;
    dp_din   = 16'h4444;
    @(negedge clk);
    check("c_rst_nodone", 64'(req_done), 64'd0);
    @(negedge clk);
    n_reset = 1'b1;
    dp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h0100 + 16'(i), 16'h0000, SREG_DS, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_reqs();
    @(negedge clk);
    check("c_post_req", 64'(dp_req), 64'd1);
    check("c_post_grant", 64'(grant_idx), 64'd0);
    check("c_post_nodone", 64'(req_done), 64'd0);
    dp_ready = 1'b1;
    dp_din   = 16'h5555;
    @(negedge clk);
    check("c_post_done", 64'(req_done), 64'b001);
    clear_all();
    dp_ready = 1'b0;

    // ce_1 held low with dp_ready high: nothing may move until ce_1 returns.
    set_req(1, 16'h0ABC, 16'h0000, SREG_DS, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_reqs();
    @(negedge clk);
    check("d_gap_req_low", 64'(dp_req), 64'd0);
    @(negedge clk);
    check("d_grant", 64'(grant_idx), 64'd1);
    ce_1     = 1'b0;
    dp_ready = 1'b1;
    dp_din   = 16'h3333;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("d_hold_req", 64'(dp_req), 64'd1);
      check("d_hold_nodone", 64'(req_done), 64'd0);
      check("d_hold_din", 64'(req_din), 64'h5555);
    end
    ce_1 = 1'b1;
    @(negedge clk);
    check("d_done", 64'(req_done), 64'b010);
    check("d_din", 64'(req_din), 64'h3333);
    act[1] = 1'b0;
    drive_reqs();
    dp_ready = 1'b0;
    @(negedge clk);
    check("d_done_once", 64'(req_done), 64'd0);

    // Table of arbitration outcomes: round robin with wrap, lock hold/release.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        act[i]    = tbl[k].valid[i];
        lk[i]     = tbl[k].lock[i];
        a_addr[i] = 16'h1000 + 16'(k * 16 + i);
        a_dout[i] = 16'hA000 + 16'(k);
        a_sreg[i] = 2'(i);
        a_wr[i]   = tbl[k].wr;
        a_wd[i]   = 1'b1;
        a_io[i]   = 1'b0;
      end
      drive_reqs();
      wait_grant($sformatf("tbl%0d_wait", k), ok);
      if (ok) begin
        check($sformatf("tbl%0d_grant", k), 64'(grant_idx), 64'(tbl[k].exp_grant));
        check($sformatf("tbl%0d_addr", k), 64'(dp_addr), 64'(a_addr[tbl[k].exp_grant]));
        dp_ready = 1'b1;
        dp_din   = 16'hD000 + 16'(k);
        @(negedge clk);
        e_done = 3'b001 << tbl[k].exp_grant;
        check($sformatf("tbl%0d_done", k), 64'(req_done), 64'(e_done));
        check($sformatf("tbl%0d_din", k), 64'(req_din), 64'(tbl[k].exp_din));
        dp_ready = 1'b0;
      end
    end

    do_reset();
    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_arbiter.md
Name: dp_arbiter

Overview:
- Shares the bus control unit's single data-pointer (dp_*) port between NREQ internal requesters, e.g. the EA operand fetch/store, stack push/pop and string/IO sequencers.
- Latches the winning request, drives the dp_* handshake to completion, and returns read data plus a one-cycle done strobe to the winner.
- Round-robin arbitration, with a lock that holds the grant across multi-access sequences such as a two-word push or read-modify-write.
- Sits between the execution sequencers and the bus control unit inside the V33 core.

Parameters:
- NREQ, 3, number of requesters (2..8).
- IW, $clog2(NREQ), grant index width (derived; do not override).

Ports:
- clk  in  1  core clock.
- n_reset  in  1  asynchronous active-low reset.
- ce_1  in  1  phase-1 clock enable; all state advances only when ce_1=1.
- req_valid  in  NREQ  per-requester request, level; held until that requester's req_done.
- req_lock  in  NREQ  keep grant after this access completes.
- req_addr  in  NREQ*16  offset, requester i in bits [16i+15:16i].
- req_dout  in  NREQ*16  write data.
- req_sreg  in  NREQ*2  segment select, sreg_index_e encoding.
- req_write  in  NREQ  1=write.
- req_wide  in  NREQ  1=16-bit access.
- req_io  in  NREQ  1=IO space.
- req_done  out  NREQ  one-ce_1-cycle completion strobe, one-hot.
- req_din  out  16  read data, valid while req_done is nonzero; holds its value otherwise.
- grant_idx  out  IW  current or last owner.
- busy  out  1  access in flight.
- dp_addr, dp_dout  out  16 each  latched payload to the bus control unit.
- dp_sreg  out  2  latched segment select.
- dp_write, dp_wide, dp_io  out  1 each  latched access attributes.
- dp_req  out  1  request to the bus control unit.
- dp_din  in  16  read data from the bus control unit.
- dp_ready  in  1  completion from the bus control unit, sampled on ce_1.

Behaviour:
- Reset (async, n_reset=0) values:
  - state=IDLE; rr_ptr=0; locked=0.
  - All outputs 0: dp_*, req_done, req_din, grant_idx, busy.
- Nothing changes unless ce_1=1. Combinational outputs are registered, so there are no comb paths from the req_* inputs to dp_*.
- FSM states are IDLE, ISSUE, GAP.
- IDLE:
  - If locked, only the owner's req_valid is considered.
  - Otherwise the winner is the first set req_valid bit scanning from rr_ptr upward, modulo NREQ.
  - On a winner: latch its payload into dp_*, set grant_idx, dp_req=1, busy=1, go to ISSUE. Issue latency is 1 ce_1 cycle from req_valid.
- ISSUE:
  - Hold dp_req and the payload stable until dp_ready=1.
  - On dp_ready: dp_req=0; req_din<=dp_din if !dp_write, else unchanged; req_done[grant_idx]=1 for exactly that cycle.
  - On dp_ready: locked<=req_lock[grant_idx]; rr_ptr<=grant_idx+1 mod NREQ (pointer unchanged if lock is kept); go to GAP.
- GAP:
  - One mandatory ce_1 cycle with dp_req=0, so the bus control unit sees a falling edge. busy=0.
  - Return to IDLE.
  - Back-to-back access throughput is 1 access per (bus time + 2) ce_1 cycles.
- Lock:
  - While locked, other requesters starve.
  - Lock releases at completion of an owner access with req_lock=0.
  - Lock also releases in IDLE if the owner's req_valid and req_lock are both 0, so the lock never deadlocks.
- Boundary conditions:
  - A requester dropping req_valid while ISSUE: the access completes anyway and req_done still pulses (harmless).
  - rr_ptr wraps from NREQ-1 to 0.
  - Non-power-of-2 NREQ: indices >= NREQ are never granted.
  - dp_ready high while not in ISSUE is ignored.
  - dp_ready in the same cycle as the ISSUE entry is not possible, because dp_req is registered.
  - n_reset asserted mid-ISSUE: dp_req drops immediately and the in-flight access is abandoned with no req_done. The bus control unit is reset by the same reset.

Decomposition:
- types package gets:
  - sreg_index_e (already present).
  - new enum dp_arb_state_e {DPA_IDLE, DPA_ISSUE, DPA_GAP}.
- One sub-module rr_pick (NREQ, IW): combinational rotate-priority picker with inputs req vector and ptr, outputs valid and idx.

Test Plan:
- Single request: req_valid=3'b010, addr=16'h1234, wide=1, read; dp_ready after 3 ce_1 with dp_din=16'hBEEF. Required: dp_req high 1 cycle after request; req_done=3'b010 for one cycle; req_din=16'hBEEF; dp_req low for >=1 cycle (GAP).
- Round robin: all three requesters continuously valid. Required: grant order 0,1,2,0,1,2; req_done one-hot each time.
- Lock: requester 1 holds req_lock=1 for two accesses while requester 0 is valid. Required: grants 1,1, then 0 only after the req_lock=0 access completes.
- Write: requester 2 writes dout=16'h00A5, sreg=SS, io=1. Required: dp_dout, dp_sreg, dp_io and dp_write stable through ISSUE; req_din unchanged.
- Async reset mid-ISSUE: n_reset low with no clk edge. Required: dp_req=0 and busy=0 immediately; no req_done; after release the first grant starts from index 0.
- ce_1 gating: ce_1 held low for 5 cycles with dp_ready=1. Required: no state change; completion occurs on the next ce_1.
